// File: rtl/example.sv
// example: registered 4-way constant-pattern lookup.
// A 2-bit select picks one of four 3x4-bit nibble patterns. The chosen
// pattern is registered, so data shows it one cycle after select is sampled.
// Element k of the pattern sits in data[4k+3:4k].
module example (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  select,
   output logic [11:0] data
);

   logic [11:0] data_d;
   logic [11:0] data_q;

   // Pattern table. Any code not listed, including X/Z in simulation,
   // falls through to the all-ones pattern.
   function automatic logic [11:0] decode_pattern(input logic [1:0] sel);
      logic [11:0] pat;
      case (sel)
         2'd0:    pat = {4'h0, 4'h1, 4'h2};
         2'd1:    pat = {4'h3, 4'h4, 4'h5};
         2'd2:    pat = {4'h6, 4'h7, 4'h8};
         default: pat = {4'hF, 4'hF, 4'hF};
      endcase
      return pat;
   endfunction

   // Decode the current select into the next output pattern.
   always_comb begin
      data_d = decode_pattern(select);
   end

   // Output register: cleared asynchronously, reloaded on every edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= 12'h000;
      end else begin
         data_q <= data_d;
      end
   end

   assign data = data_q;

endmodule

// File: tb/tb_example.sv
// tb_example: scoreboard bench for the registered pattern lookup.
module tb_example;

   logic        clk;
   logic        rst_n;
   logic [1:0]  sel;
   logic [11:0] data;
   logic [2:0]  cnt;

   int n_checks;
   int n_fail;

   logic [11:0] exp_q[$];

   example dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .select (sel),
      .data   (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference pattern table; X/Z bits on select map to all-ones.
   function automatic logic [11:0] ref_pattern(input logic [1:0] s);
      if (s === 2'b00)      return 12'h012;
      else if (s === 2'b01) return 12'h345;
      else if (s === 2'b10) return 12'h678;
      else                  return 12'hFFF;
   endfunction

   task automatic check_eq(input string tag, input logic [11:0] got,
                           input logic [11:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pop the oldest expected value and compare it against data.
   task automatic check_pop(input string tag);
      logic [11:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got %h expected <empty scoreboard>", tag, data);
      end else begin
         e = exp_q.pop_front();
         check_eq(tag, data, e);
      end
   endtask

   // Drive select away from the rising edge, then check after the edge.
   task automatic step(input string tag, input logic [1:0] s);
      @(negedge clk);
      sel = s;
      exp_q.push_back(ref_pattern(s));
      @(posedge clk);
      #1;
      check_pop(tag);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      sel      = 2'd2;
      cnt      = 3'd0;

      // Reset held with clock running.
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_after_edge", data, 12'h000);
      @(negedge clk);
      #2;
      check_eq("reset_between_edges", data, 12'h000);

      // Release reset; first edge loads pattern for select=2.
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(ref_pattern(sel));
      @(posedge clk);
      #1;
      check_pop("reset_release");

      // Full sweep.
      for (int s = 0; s < 4; s++) step("sweep", 2'(s));

      // Truncation of a 3-bit counter to the low two bits.
      for (int i = 0; i < 8; i++) begin
         cnt = 3'(i);
         step("trunc", cnt[1:0]);
      end

      // Mid-cycle select change must not reach data.
      step("mid_setup", 2'd1);
      #2;
      sel = 2'd2;
      #1;
      check_eq("mid_to2", data, 12'h345);
      #2;
      sel = 2'd1;
      #1;
      check_eq("mid_back1", data, 12'h345);
      @(posedge clk);
      #1;
      check_eq("mid_after_edge", data, 12'h345);

      // Asynchronous reset pulse between edges.
      step("async_setup", 2'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_assert", data, 12'h000);
      #1;
      rst_n = 1'b1;
      #1;
      check_eq("async_hold_until_edge", data, 12'h000);
      @(posedge clk);
      #1;
      check_eq("async_restore", data, 12'hFFF);

      // Partially unknown select.
      @(negedge clk);
      sel = 2'bx1;
      exp_q.push_back(ref_pattern(sel));
      @(posedge clk);
      #1;
      check_pop("x_select");

      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
